// File: rtl/eth_stream_pkt_arbiter_if.sv
// Stream bundle for eth_stream_pkt_arbiter.
// Holds the NUM_PORTS requester streams (i_valid/i_data/i_sop/i_eop/i_mod in,
// o_ready out), the shared output stream (o_valid/o_data/o_sop/o_eop/o_mod
// out, i_ready in) and the status outputs (o_grant, o_pkt_count, o_sop_err).
// Signal prefixes are from the arbiter's point of view.
//   slave  : arbiter side
//   master : requesters + downstream sink side (environment)

`ifndef ACX_NAP_ETH_DATA_WIDTH
`define ACX_NAP_ETH_DATA_WIDTH 256
`endif

interface eth_stream_pkt_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = `ACX_NAP_ETH_DATA_WIDTH,
    parameter int MOD_WIDTH  = $clog2(DATA_WIDTH/8)
);
    logic [NUM_PORTS-1:0]            i_valid;
    logic [NUM_PORTS-1:0]            o_ready;
    logic [NUM_PORTS*DATA_WIDTH-1:0] i_data;
    logic [NUM_PORTS-1:0]            i_sop;
    logic [NUM_PORTS-1:0]            i_eop;
    logic [NUM_PORTS*MOD_WIDTH-1:0]  i_mod;

    logic                            o_valid;
    logic                            i_ready;
    logic [DATA_WIDTH-1:0]           o_data;
    logic                            o_sop;
    logic                            o_eop;
    logic [MOD_WIDTH-1:0]            o_mod;

    logic [NUM_PORTS-1:0]            o_grant;
    logic [NUM_PORTS*32-1:0]         o_pkt_count;
    logic [NUM_PORTS-1:0]            o_sop_err;

    modport slave (
        input  i_valid, i_data, i_sop, i_eop, i_mod, i_ready,
        output o_ready, o_valid, o_data, o_sop, o_eop, o_mod,
        output o_grant, o_pkt_count, o_sop_err
    );

    modport master (
        output i_valid, i_data, i_sop, i_eop, i_mod, i_ready,
        input  o_ready, o_valid, o_data, o_sop, o_eop, o_mod,
        input  o_grant, o_pkt_count, o_sop_err
    );
endinterface

// File: rtl/eth_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Ethernet NAP transmit
// stream between NUM_PORTS requesters. A granted port owns the output until
// its eop beat is accepted, so frames never interleave.
// Ports:
//   i_clk     : clock
//   i_reset_n : synchronous active-low reset
//   bus       : eth_stream_pkt_arbiter_if.slave (requester streams, output
//               stream, one-hot grant, per-port packet counts, sticky
//               per-port sop errors)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick next eligible (valid & sop) port round-robin
// PKT   | granted port forwarded combinationally until eop accepted

`ifndef ACX_NAP_ETH_DATA_WIDTH
`define ACX_NAP_ETH_DATA_WIDTH 256
`endif

module eth_stream_pkt_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = `ACX_NAP_ETH_DATA_WIDTH,
    parameter int MOD_WIDTH  = $clog2(DATA_WIDTH/8)
) (
    input logic                     i_clk,
    input logic                     i_reset_n,
    eth_stream_pkt_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {ST_IDLE, ST_PKT} state_t;

    state_t               state;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     last_grant;
    logic [NUM_PORTS-1:0] grant_oh;
    logic [NUM_PORTS-1:0] sop_err;
    logic [31:0]          pkt_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] eligible;
    logic                 any_eligible;
    logic [IDX_W-1:0]     next_idx;
    logic                 sel_valid;
    logic                 sel_eop;
    logic                 fwd_active;
    logic                 accept_eop;

    // Round-robin pick: scan from last_grant+N down to last_grant+1 so the
    // final overwrite is the nearest eligible port above last_grant.
    always_comb begin
        eligible     = bus.i_valid & bus.i_sop;
        any_eligible = |eligible;
        next_idx     = last_grant;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            int cand;
            cand = int'(last_grant) + i;
            if (cand >= NUM_PORTS)
                cand = cand - NUM_PORTS;
            if (eligible[IDX_W'(cand)])
                next_idx = IDX_W'(cand);
        end
    end

    // Zero-latency forwarding of the granted port. Reset also gates the path
    // so no beat is handed over on the cycle reset is asserted mid-frame.
    always_comb begin
        bus.o_data = '0;
        bus.o_sop  = 1'b0;
        bus.o_mod  = '0;
        sel_valid  = 1'b0;
        sel_eop    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == IDX_W'(p)) begin
                bus.o_data = bus.i_data[p*DATA_WIDTH +: DATA_WIDTH];
                bus.o_sop  = bus.i_sop[p];
                bus.o_mod  = bus.i_mod[p*MOD_WIDTH +: MOD_WIDTH];
                sel_valid  = bus.i_valid[p];
                sel_eop    = bus.i_eop[p];
            end
        end
        bus.o_eop   = sel_eop;
        fwd_active  = (state == ST_PKT) && i_reset_n;
        bus.o_valid = fwd_active && sel_valid;
        bus.o_ready = fwd_active ? (grant_oh & {NUM_PORTS{bus.i_ready}}) : '0;
        accept_eop  = bus.o_valid && bus.i_ready && sel_eop;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            grant_oh   <= '0;
            sop_err    <= '0;
            for (int p = 0; p < NUM_PORTS; p++)
                pkt_cnt[p] <= '0;
        end else begin
            // grant_oh is zero in IDLE, so any mid-frame beat seen there flags.
            sop_err <= sop_err | (bus.i_valid & ~bus.i_sop & ~grant_oh);
            case (state)
                ST_IDLE: begin
                    if (any_eligible) begin
                        grant_idx  <= next_idx;
                        last_grant <= next_idx;
                        grant_oh   <= NUM_PORTS'(1) << next_idx;
                        state      <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (accept_eop) begin
                        pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 32'd1;
                        grant_oh           <= '0;
                        state              <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_grant   = grant_oh;
    assign bus.o_sop_err = sop_err;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        assign bus.o_pkt_count[p*32 +: 32] = pkt_cnt[p];
    end
endmodule
